// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite scheduler.
package sprite_pkg;

  typedef struct packed {
    logic [6:0] dim;
    logic [4:0] id;
    logic [9:0] y;
    logic [9:0] x;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } sstate_t;

  localparam logic [4:0] SPRITE_ID_SHIP = 5'd0;
  localparam logic [4:0] SPRITE_ID_PIG  = 5'd2;
  localparam logic [4:0] SPRITE_ID_BEE  = 5'd3;
  localparam int         TRANSPARENT    = 0;

  // Screen columns carry one extra bit so x+col never wraps.
  localparam int SPRITE_COL_W = 11;

endpackage

// File: rtl/sprite_rom_pipe.sv
// Carries (valid, screen column) alongside each ROM read so it lines up with rom_data.
module sprite_rom_pipe
  import sprite_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int COL_W   = SPRITE_COL_W
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [COL_W-1:0] col_i,
  output logic             valid_o,
  output logic [COL_W-1:0] col_o
);

  logic [ROM_LAT-1:0] valid_q;
  logic [COL_W-1:0]   col_q [ROM_LAT];

  always_ff @(posedge clk_i) begin
    if (!rst_b_i || flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < ROM_LAT; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      for (int i = 0; i < ROM_LAT; i++) col_q[i] <= '0;
    end else begin
      col_q[0] <= col_i;
      for (int i = 1; i < ROM_LAT; i++) col_q[i] <= col_q[i-1];
    end
  end

  assign valid_o = valid_q[ROM_LAT-1];
  assign col_o   = col_q[ROM_LAT-1];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Prepares one scanline: clears the line buffer, then draws hit sprites from a shared ROM port.
//   state   | meaning
//   IDLE    | waiting for line_start
//   CLEAR   | zeroing line buffer columns 0..H_ACTIVE-1
//   SCAN    | testing descriptor idx against cur_line
//   FETCH   | issuing one ROM read per sprite column
//   DRAIN   | letting the last ROM_LAT reads return
//   DONE    | pulsing line_done
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int H_ACTIVE    = 640,
  parameter int ADDR_W      = 10,
  parameter int PIX_W       = 24,
  parameter int ROM_LAT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     line_start,
  input  logic [9:0]               next_line,
  input  logic [32*NUM_SPRITES-1:0] sprite_desc,
  input  logic                     overrun_clr,
  output logic [4:0]               rom_id,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic                     rom_rd,
  input  logic [PIX_W-1:0]         rom_data,
  output logic                     lb_we,
  output logic [9:0]               lb_addr,
  output logic [PIX_W-1:0]         lb_wdata,
  output logic                     busy,
  output logic                     line_done,
  output logic                     overrun
);

  localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int PROD_W = ADDR_W + 14;
  localparam int DRN_W  = $clog2(ROM_LAT + 1);
  localparam int COL_W  = SPRITE_COL_W;

  sstate_t           state_q;
  desc_t             desc_q [NUM_SPRITES];
  logic [9:0]        cur_line_q;
  logic [9:0]        clr_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [6:0]        row_q;
  logic [6:0]        col_q;
  logic [DRN_W-1:0]  drain_q;
  logic [COL_W-1:0]  rd_col_q;

  logic [4:0]        rom_id_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_rd_q;
  logic              lb_we_q;
  logic [9:0]        lb_addr_q;
  logic [PIX_W-1:0]  lb_wdata_q;
  logic              busy_q;
  logic              line_done_q;
  logic              overrun_q;

  desc_t             cur;
  logic [COL_W-1:0]  line_ext;
  logic [COL_W-1:0]  y_ext;
  logic              hit;
  logic              pipe_valid;
  logic [COL_W-1:0]  pipe_col;
  logic              pix_wr;

  assign cur      = desc_q[idx_q];
  assign line_ext = {1'b0, cur_line_q};
  assign y_ext    = {1'b0, cur.y};
  assign hit      = (cur.dim != 7'd0) && (line_ext >= y_ext) &&
                    (line_ext < y_ext + COL_W'(cur.dim));
  assign pix_wr   = pipe_valid && (pipe_col < COL_W'(H_ACTIVE)) &&
                    (rom_data != PIX_W'(TRANSPARENT));

  // Any line_start discards reads still in flight for the old line.
  sprite_rom_pipe #(
    .ROM_LAT (ROM_LAT),
    .COL_W   (COL_W)
  ) u_pipe (
    .clk_i   (clk),
    .rst_b_i (reset),
    .flush_i (line_start),
    .valid_i (rom_rd_q),
    .col_i   (rd_col_q),
    .valid_o (pipe_valid),
    .col_o   (pipe_col)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NUM_SPRITES; i++) desc_q[i] <= '0;
      cur_line_q <= '0;
      clr_cnt_q  <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      drain_q    <= '0;
      rd_col_q   <= '0;
      rom_id_q   <= '0;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
      busy_q     <= 1'b0;
      line_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rom_rd_q    <= 1'b0;
      lb_we_q     <= 1'b0;
      line_done_q <= 1'b0;
      if (overrun_clr) overrun_q <= 1'b0;

      if (line_start) begin
        if (state_q != S_IDLE) overrun_q <= 1'b1;
        for (int i = 0; i < NUM_SPRITES; i++) desc_q[i] <= desc_t'(sprite_desc[32*i +: 32]);
        cur_line_q <= next_line;
        clr_cnt_q  <= '0;
        busy_q     <= 1'b1;
        state_q    <= S_CLEAR;
      end else begin
        if (pix_wr) begin
          lb_we_q    <= 1'b1;
          lb_addr_q  <= pipe_col[9:0];
          lb_wdata_q <= rom_data;
        end
        case (state_q)
          S_IDLE: ;
          S_CLEAR: begin
            lb_we_q    <= 1'b1;
            lb_addr_q  <= clr_cnt_q;
            lb_wdata_q <= '0;
            if (clr_cnt_q == 10'(H_ACTIVE - 1)) begin
              idx_q   <= IDX_W'(NUM_SPRITES - 1);
              state_q <= S_SCAN;
            end else begin
              clr_cnt_q <= clr_cnt_q + 10'd1;
            end
          end
          S_SCAN: begin
            if (hit) begin
              row_q   <= 7'(line_ext - y_ext);
              col_q   <= '0;
              state_q <= S_FETCH;
            end else if (idx_q == '0) begin
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
          S_FETCH: begin
            rom_rd_q   <= 1'b1;
            rom_id_q   <= cur.id;
            rom_addr_q <= ADDR_W'(PROD_W'(row_q) * PROD_W'(cur.dim) + PROD_W'(col_q));
            rd_col_q   <= COL_W'(cur.x) + COL_W'(col_q);
            if (col_q == cur.dim - 7'd1) begin
              drain_q <= DRN_W'(ROM_LAT - 1);
              state_q <= S_DRAIN;
            end else begin
              col_q <= col_q + 7'd1;
            end
          end
          S_DRAIN: begin
            if (drain_q == '0) begin
              if (idx_q == '0) begin
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_q - 1'b1;
                state_q <= S_SCAN;
              end
            end else begin
              drain_q <= drain_q - 1'b1;
            end
          end
          S_DONE: begin
            line_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_id    = rom_id_q;
  assign rom_addr  = rom_addr_q;
  assign rom_rd    = rom_rd_q;
  assign lb_we     = lb_we_q;
  assign lb_addr   = lb_addr_q;
  assign lb_wdata  = lb_wdata_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a 2-cycle ROM model and a line buffer model.
module tb_sprite_line_scheduler;

  localparam int NS = 8;
  localparam int H  = 640;
  localparam int AW = 10;
  localparam int PW = 24;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              line_start;
  logic [9:0]        next_line;
  logic [32*NS-1:0]  sprite_desc;
  logic              overrun_clr;
  logic [4:0]        rom_id;
  logic [AW-1:0]     rom_addr;
  logic              rom_rd;
  logic [PW-1:0]     rom_data;
  logic              lb_we;
  logic [9:0]        lb_addr;
  logic [PW-1:0]     lb_wdata;
  logic              busy;
  logic              line_done;
  logic              overrun;

  always #5 clk = ~clk;

  sprite_line_scheduler #(
    .NUM_SPRITES (NS),
    .H_ACTIVE    (H),
    .ADDR_W      (AW),
    .PIX_W       (PW),
    .ROM_LAT     (RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .next_line   (next_line),
    .sprite_desc (sprite_desc),
    .overrun_clr (overrun_clr),
    .rom_id      (rom_id),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .lb_we       (lb_we),
    .lb_addr     (lb_addr),
    .lb_wdata    (lb_wdata),
    .busy        (busy),
    .line_done   (line_done),
    .overrun     (overrun)
  );

  // Sprite ROM contents: id 0 has a transparent pixel at address 1, id 3 is solid blue.
  function automatic logic [PW-1:0] romf(input logic [4:0] id, input logic [AW-1:0] a);
    case (id)
      5'd0:    romf = (a == 10'd1) ? 24'h0 : (24'h100000 | 24'(a));
      5'd3:    romf = 24'h0000FF;
      default: romf = 24'(a) + 24'd1;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int dim, input int id, input int y, input int x);
    return {dim[6:0], id[4:0], y[9:0], x[9:0]};
  endfunction

  // Two-stage ROM: data for a read seen in cycle c is presented in cycle c+2.
  logic          rd1 = 1'b0;
  logic [PW-1:0] d1  = '0;
  always @(posedge clk) begin
    rd1      <= rom_rd;
    d1       <= romf(rom_id, rom_addr);
    rom_data <= rd1 ? d1 : 24'hDEAD00;
  end

  int            cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, lbwe_cnt = 0;
  int            rd_line = 0, lbwe_line = 0, nz_line = 0;
  longint        asum_line = 0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic [4:0]    last_id = '0;
  logic [PW-1:0] lb_mem [H];

  always @(posedge clk) begin
    if (lb_we) begin
      lbwe_cnt++;
      lbwe_line++;
      if (lb_wdata != '0) nz_line++;
      asum_line += longint'(lb_addr);
      if (int'(lb_addr) < H) lb_mem[int'(lb_addr)] = lb_wdata;
    end
    if (rom_rd) begin
      if (rd_line == 0) first_addr = rom_addr;
      last_addr = rom_addr;
      last_id   = rom_id;
      rd_line++;
    end
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (line_start) begin
      start_cyc = cyc;
      rd_line   = 0;
      lbwe_line = 0;
      nz_line   = 0;
      asum_line = 0;
    end
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input int nl);
    @(negedge clk);
    line_start = 1'b1;
    next_line  = 10'(nl);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    check("line_done_seen", done_cnt - d0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rom_rd) break;
    end
    check("reach_fetch", {31'b0, rom_rd}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, w0;
    reset       = 1'b0;
    line_start  = 1'b0;
    overrun_clr = 1'b0;
    next_line   = '0;
    sprite_desc = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {27'b0, busy, lb_we, rom_rd, line_done, overrun}, 0);
    check("reset_busses", {7'b0, rom_id, rom_addr, lb_addr}, 0);
    reset = 1'b1;
    @(negedge clk);

    // All sprites disabled: clear only.
    start_line(5);
    wait_done();
    check("clr_latency", done_cyc - start_cyc, 650);
    check("clr_writes", lbwe_line, 640);
    check("clr_nonzero", nz_line, 0);
    check("clr_addr_sum", 32'(asum_line), 204480);
    check("clr_rom_rd", rd_line, 0);
    check("clr_idle_busy", {31'b0, busy}, 0);

    // Single hit; descriptors change after the snapshot and must be ignored.
    sprite_desc = '0;
    sprite_desc[31:0] = mk(16, 2, 10, 100);
    start_line(12);
    sprite_desc = '0;
    wait_done();
    check("hit_latency", done_cyc - start_cyc, 668);
    check("hit_reads", rd_line, 16);
    check("hit_first_addr", 32'(first_addr), 32);
    check("hit_last_addr", 32'(last_addr), 47);
    check("hit_rom_id", 32'(last_id), 2);
    check("hit_col100", 32'(lb_mem[100]), 33);
    check("hit_col115", 32'(lb_mem[115]), 48);
    check("hit_col99", 32'(lb_mem[99]), 0);
    check("hit_col116", 32'(lb_mem[116]), 0);
    check("hit_writes", lbwe_line, 656);

    // Transparency and priority: sprite 0 over sprite 1.
    sprite_desc = '0;
    sprite_desc[31:0]  = mk(4, 0, 0, 200);
    sprite_desc[63:32] = mk(4, 3, 0, 200);
    start_line(0);
    wait_done();
    check("pri_latency", done_cyc - start_cyc, 662);
    check("pri_reads", rd_line, 8);
    check("pri_writes", lbwe_line, 647);
    check("pri_col200", 32'(lb_mem[200]), 32'h100000);
    check("pri_col201", 32'(lb_mem[201]), 32'h0000FF);
    check("pri_col202", 32'(lb_mem[202]), 32'h100002);
    check("pri_col203", 32'(lb_mem[203]), 32'h100003);
    check("pri_col204", 32'(lb_mem[204]), 0);

    // Right-edge clip plus vertical hit boundaries.
    sprite_desc = '0;
    sprite_desc[31:0]   = mk(8, 2, 50, 636);
    sprite_desc[63:32]  = mk(5, 2, 51, 300);
    sprite_desc[95:64]  = mk(10, 2, 40, 300);
    sprite_desc[127:96] = mk(1, 2, 50, 0);
    start_line(50);
    wait_done();
    check("clip_latency", done_cyc - start_cyc, 663);
    check("clip_reads", rd_line, 9);
    check("clip_writes", lbwe_line, 645);
    check("clip_last_addr", 32'(last_addr), 7);
    check("clip_col0", 32'(lb_mem[0]), 1);
    check("clip_col636", 32'(lb_mem[636]), 1);
    check("clip_col639", 32'(lb_mem[639]), 4);
    check("clip_col300", 32'(lb_mem[300]), 0);
    check("clip_col201_cleared", 32'(lb_mem[201]), 0);

    // Overrun during FETCH.
    sprite_desc = '0;
    sprite_desc[31:0] = mk(16, 2, 10, 100);
    start_line(12);
    wait_rd();
    d0 = done_cnt;
    start_line(12);
    check("ovr_set", {30'b0, overrun, busy}, 3);
    wait_done();
    check("ovr_one_done", done_cnt - d0, 1);
    check("ovr_restart_latency", done_cyc - start_cyc, 668);
    check("ovr_restart_writes", lbwe_line, 656);
    check("ovr_sticky", {31'b0, overrun}, 1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", {31'b0, overrun}, 0);

    // Set and clear in the same cycle: set wins.
    start_line(12);
    repeat (5) @(negedge clk);
    line_start  = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    line_start  = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", {31'b0, overrun}, 1);
    wait_done();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared2", {31'b0, overrun}, 0);

    // Reset in the middle of FETCH abandons the line.
    start_line(12);
    wait_rd();
    d0 = done_cnt;
    w0 = lbwe_cnt;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_mid_flags", {27'b0, busy, lb_we, rom_rd, line_done, overrun}, 0);
    repeat (30) @(negedge clk);
    check("rst_mid_no_writes", lbwe_cnt - w0, 0);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", {30'b0, busy, rom_rd}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
